// File: rtl/axis_dac_feeder_if.sv
// AXI4-Stream bundle shared by the DMA-facing input and the DAC-facing output
// of axis_dac_feeder.
interface axis_dac_feeder_if;
   logic [255:0] tdata;
   logic [31:0]  tkeep;
   logic         tlast;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_dac_feeder.sv
// Buffers MM2S stream words in a small FIFO and plays them as a gap-free RF-DAC stream.
// Optional statistics counters are enabled by defining AXIS_DAC_FEEDER_STATS_EN.
module axis_dac_feeder #(
   parameter int FIFO_DEPTH  = 16,
   parameter int PRIME_LEVEL = 8
) (
   input  logic                        axi_aclk,
   input  logic                        axi_rstb,
   axis_dac_feeder_if.slave            s_axis,
   axis_dac_feeder_if.master           m_axis,
   input  logic                        play_en,
   input  logic                        fifo_flush,
   input  logic                        status_clr,
   output logic                        underflow,
   output logic                        keep_err,
   output logic [15:0]                 underflow_cnt,
   output logic [15:0]                 frame_cnt,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [1:0]                  state
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, PLAY = 2'd2} state_e;

   state_e        state_q;
   logic [255:0]  out_q;
   logic [255:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          underflow_q;
   logic          keep_err_q;
   logic [255:0]  wr_data;
   logic [255:0]  head;
   logic          fifo_empty;
   logic          wr_en;
   logic          prime_go;
   logic          play_go;
   logic          pop;
   logic          zero_fill;
   logic          keep_evt;

   assign fifo_empty    = (level_q == '0);
   assign s_axis.tready = (level_q != FULL_LVL);
   assign wr_en         = s_axis.tvalid && (level_q != FULL_LVL) && !fifo_flush;
   assign head          = mem_q[rd_ptr_q];
   assign prime_go      = (state_q == PRIME) && play_en && (level_q >= PRIME_LVL);
   assign play_go       = (state_q == PLAY) && play_en && m_axis.tready;
   assign pop           = prime_go || (play_go && !fifo_empty);
   assign zero_fill     = play_go && fifo_empty;
   assign keep_evt      = wr_en && (s_axis.tkeep != 32'hFFFF_FFFF);

   // Disabled byte lanes are stored as zero so the DAC never sees stale bytes.
   always_comb begin
      wr_data = '0;
      for (int i = 0; i < 32; i++) begin
         wr_data[8*i +: 8] = s_axis.tkeep[i] ? s_axis.tdata[8*i +: 8] : 8'h00;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !pop)      level_d = level_q + LW'(1);
      else if (pop && !wr_en) level_d = level_q - LW'(1);
      if (fifo_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_rstb) begin
      if (!axi_rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   // Entering PLAY also loads the first word, so tvalid never rises on a zero word.
   always_ff @(posedge axi_aclk or negedge axi_rstb) begin
      if (!axi_rstb) begin
         state_q <= IDLE;
         out_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               out_q <= '0;
               if (play_en) state_q <= PRIME;
            end
            PRIME: begin
               if (!play_en) begin
                  state_q <= IDLE;
                  out_q   <= '0;
               end else if (prime_go) begin
                  state_q <= PLAY;
                  out_q   <= head;
               end
            end
            PLAY: begin
               if (!play_en) begin
                  state_q <= IDLE;
                  out_q   <= '0;
               end else if (m_axis.tready) begin
                  out_q <= fifo_empty ? '0 : head;
               end
            end
            default: begin
               state_q <= IDLE;
               out_q   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_rstb) begin
      if (!axi_rstb) begin
         underflow_q <= 1'b0;
         keep_err_q  <= 1'b0;
      end else begin
         underflow_q <= zero_fill || (underflow_q && !status_clr);
         keep_err_q  <= keep_evt || (keep_err_q && !status_clr);
      end
   end

`ifdef AXIS_DAC_FEEDER_STATS_EN
   logic [15:0] ucnt_q;
   logic [15:0] fcnt_q;
   logic        frame_evt;

   assign frame_evt = wr_en && s_axis.tlast;

   // A same-cycle event beats the clear, leaving the counter at one.
   always_ff @(posedge axi_aclk or negedge axi_rstb) begin
      if (!axi_rstb) begin
         ucnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         if (status_clr)                          ucnt_q <= zero_fill ? 16'd1 : 16'd0;
         else if (zero_fill && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
         if (status_clr)     fcnt_q <= frame_evt ? 16'd1 : 16'd0;
         else if (frame_evt) fcnt_q <= fcnt_q + 16'd1;
      end
   end

   assign underflow_cnt = ucnt_q;
   assign frame_cnt     = fcnt_q;
`else
   assign underflow_cnt = '0;
   assign frame_cnt     = '0;
`endif

   assign m_axis.tdata  = out_q;
   assign m_axis.tvalid = (state_q == PLAY);
   assign m_axis.tkeep  = 32'hFFFF_FFFF;
   assign m_axis.tlast  = 1'b0;
   assign underflow     = underflow_q;
   assign keep_err      = keep_err_q;
   assign fifo_level    = level_q;
   assign state         = state_q;
endmodule

// File: tb/tb_axis_dac_feeder.sv
// Self-checking bench for axis_dac_feeder: directed scenarios plus a randomized run
// against a queue-based reference model of the feeder.
module tb_axis_dac_feeder;
   localparam int DEPTH = 16;
   localparam int PRIME = 8;
`ifdef AXIS_DAC_FEEDER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic        playEn = 1'b0;
   logic        fifoFlush = 1'b0;
   logic        statusClr = 1'b0;
   logic        underflow, keepErr;
   logic [15:0] underflowCnt, frameCnt;
   logic [4:0]  fifoLevel;
   logic [1:0]  state;
   int          checks = 0;
   int          errors = 0;

   axis_dac_feeder_if sIf ();
   axis_dac_feeder_if mIf ();

   axis_dac_feeder #(.FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
      .axi_aclk      (clk),
      .axi_rstb      (rstb),
      .s_axis        (sIf),
      .m_axis        (mIf),
      .play_en       (playEn),
      .fifo_flush    (fifoFlush),
      .status_clr    (statusClr),
      .underflow     (underflow),
      .keep_err      (keepErr),
      .underflow_cnt (underflowCnt),
      .frame_cnt     (frameCnt),
      .fifo_level    (fifoLevel),
      .state         (state)
   );

   always #5 clk = ~clk;

   // Reference model: the FIFO is a queue, the player a three-mode state variable.
   logic [255:0] mq[$];
   int           mState = 0;
   logic [255:0] mOut = '0;
   bit           mUf = 1'b0;
   bit           mKe = 1'b0;
   int           mUcnt = 0;
   int           mFcnt = 0;

   function automatic logic [255:0] maskWord(input logic [255:0] d, input logic [31:0] k);
      logic [255:0] r;
      r = d;
      for (int i = 0; i < 32; i++) if (!k[i]) r[8*i +: 8] = 8'h00;
      return r;
   endfunction

   function automatic logic [255:0] randWord();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   always @(posedge clk or negedge rstb) begin : modelStep
      int           sz;
      logic [255:0] head;
      bit           wr, pop, ufEvt, lastEvt;
      if (!rstb) begin
         mq.delete();
         mState = 0;
         mOut   = '0;
         mUf    = 1'b0;
         mKe    = 1'b0;
         mUcnt  = 0;
         mFcnt  = 0;
      end else begin
         sz    = mq.size();
         head  = (sz > 0) ? mq[0] : '0;
         wr    = sIf.tvalid && (sz != DEPTH) && !fifoFlush;
         pop   = 1'b0;
         ufEvt = 1'b0;
         case (mState)
            0: begin
               mOut = '0;
               if (playEn) mState = 1;
            end
            1: begin
               if (!playEn) begin
                  mState = 0;
                  mOut   = '0;
               end else if (sz >= PRIME) begin
                  mState = 2;
                  mOut   = head;
                  pop    = 1'b1;
               end
            end
            default: begin
               if (!playEn) begin
                  mState = 0;
                  mOut   = '0;
               end else if (mIf.tready) begin
                  if (sz > 0) begin
                     mOut = head;
                     pop  = 1'b1;
                  end else begin
                     mOut  = '0;
                     ufEvt = 1'b1;
                  end
               end
            end
         endcase
         if (pop) void'(mq.pop_front());
         if (fifoFlush) mq.delete();
         else if (wr) mq.push_back(maskWord(sIf.tdata, sIf.tkeep));
         lastEvt = wr && sIf.tlast;
         mUf = ufEvt || (mUf && !statusClr);
         mKe = (wr && sIf.tkeep != 32'hFFFF_FFFF) || (mKe && !statusClr);
         if (statusClr) mUcnt = ufEvt ? 1 : 0;
         else if (ufEvt && mUcnt < 65535) mUcnt = mUcnt + 1;
         if (statusClr) mFcnt = lastEvt ? 1 : 0;
         else if (lastEvt) mFcnt = (mFcnt + 1) % 65536;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic quiesce();
      playEn     = 1'b0;
      sIf.tvalid = 1'b0;
      sIf.tkeep  = 32'hFFFF_FFFF;
      sIf.tlast  = 1'b0;
      mIf.tready = 1'b0;
      fifoFlush  = 1'b1;
      statusClr  = 1'b1;
      tick();
      fifoFlush  = 1'b0;
      statusClr  = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({sIf.tready, mIf.tvalid, fifoLevel, state} !== {1'b1, 1'b0, 5'd0, 2'd0}) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got %b exp %b", {sIf.tready, mIf.tvalid, fifoLevel, state}, {1'b1, 1'b0, 5'd0, 2'd0});
      end
      checks++;
      if (mIf.tdata !== 256'd0) begin
         errors++;
         $display("[TB] FAIL reset_tdata got %h exp 0", mIf.tdata);
      end
      checks++;
      if ({underflow, keepErr, underflowCnt, frameCnt} !== 34'd0) begin
         errors++;
         $display("[TB] FAIL reset_status got %h exp 0", {underflow, keepErr, underflowCnt, frameCnt});
      end
      @(negedge clk);
      rstb = 1'b1;
      tick();
   endtask

   task automatic test_prime_play();
      logic [255:0] words [8];
      for (int i = 0; i < 8; i++) words[i] = randWord();
      playEn     = 1'b1;
      mIf.tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sIf.tvalid = 1'b1;
         sIf.tdata  = words[i];
         sIf.tkeep  = 32'hFFFF_FFFF;
         sIf.tlast  = 1'b0;
         tick();
         checks++;
         if (mIf.tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prime_valid_low push %0d got %b exp 0", i, mIf.tvalid);
         end
      end
      sIf.tvalid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if ({mIf.tvalid, mIf.tdata} !== {1'b1, words[k]}) begin
            errors++;
            $display("[TB] FAIL play_word %0d got %b/%h exp 1/%h", k, mIf.tvalid, mIf.tdata, words[k]);
         end
         checks++;
         if (underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL play_no_underflow %0d got %b exp 0", k, underflow);
         end
      end
   endtask

   task automatic test_underflow();
      logic [15:0] expCnt;
      for (int k = 0; k < 6; k++) begin
         tick();
         expCnt = STATS ? 16'(k + 1) : 16'd0;
         checks++;
         if ({mIf.tvalid, mIf.tdata, state} !== {1'b1, 256'd0, 2'd2}) begin
            errors++;
            $display("[TB] FAIL uf_output %0d got %b/%h/%0d exp 1/0/2", k, mIf.tvalid, mIf.tdata, state);
         end
         checks++;
         if ({underflow, underflowCnt} !== {1'b1, expCnt}) begin
            errors++;
            $display("[TB] FAIL uf_status %0d got %b/%0d exp 1/%0d", k, underflow, underflowCnt, expCnt);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] words [20];
      int           got;
      logic         nextReady;
      quiesce();
      for (int i = 0; i < 20; i++) begin
         words[i]   = randWord();
         sIf.tvalid = 1'b1;
         sIf.tdata  = words[i];
         tick();
      end
      sIf.tvalid = 1'b0;
      checks++;
      if ({sIf.tready, fifoLevel} !== {1'b0, 5'd16}) begin
         errors++;
         $display("[TB] FAIL bp_full got ready %b level %0d exp ready 0 level 16", sIf.tready, fifoLevel);
      end
      got    = 0;
      playEn = 1'b1;
      for (int c = 0; c < 300 && got < 16; c++) begin
         nextReady = 1'($urandom_range(0, 1));
         if (mIf.tvalid && nextReady) begin
            checks++;
            if ({mIf.tdata, underflow} !== {words[got], 1'b0}) begin
               errors++;
               $display("[TB] FAIL bp_order %0d got %h uf %b exp %h uf 0", got, mIf.tdata, underflow, words[got]);
            end
            got++;
         end
         mIf.tready = nextReady;
         tick();
         checks++;
         if ({mIf.tvalid, fifoLevel, mIf.tdata} !== {mState == 2, 5'(mq.size()), mOut}) begin
            errors++;
            $display("[TB] FAIL bp_model cyc %0d got %b/%0d/%h exp %b/%0d/%h", c, mIf.tvalid, fifoLevel, mIf.tdata, mState == 2, mq.size(), mOut);
         end
      end
      checks++;
      if (got != 16) begin
         errors++;
         $display("[TB] FAIL bp_count got %0d exp 16", got);
      end
   endtask

   task automatic test_keep_last();
      logic [255:0] w0;
      bit           seen;
      logic [15:0]  expF;
      quiesce();
      w0         = randWord();
      sIf.tvalid = 1'b1;
      sIf.tdata  = w0;
      sIf.tkeep  = 32'h0000_FFFF;
      sIf.tlast  = 1'b1;
      tick();
      expF = STATS ? 16'd1 : 16'd0;
      checks++;
      if ({keepErr, frameCnt} !== {1'b1, expF}) begin
         errors++;
         $display("[TB] FAIL keep_flags got %b/%0d exp 1/%0d", keepErr, frameCnt, expF);
      end
      sIf.tkeep = 32'hFFFF_FFFF;
      sIf.tlast = 1'b0;
      for (int i = 0; i < 7; i++) begin
         sIf.tdata = randWord();
         tick();
      end
      sIf.tvalid = 1'b0;
      playEn     = 1'b1;
      mIf.tready = 1'b1;
      seen       = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         tick();
         if (mIf.tvalid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || mIf.tdata !== {128'd0, w0[127:0]}) begin
         errors++;
         $display("[TB] FAIL keep_masked seen %b got %h exp %h", seen, mIf.tdata, {128'd0, w0[127:0]});
      end
      playEn     = 1'b0;
      mIf.tready = 1'b0;
      tick();
      sIf.tvalid = 1'b1;
      sIf.tdata  = randWord();
      sIf.tlast  = 1'b1;
      statusClr  = 1'b1;
      tick();
      checks++;
      if ({keepErr, frameCnt, underflow} !== {1'b0, expF, 1'b0}) begin
         errors++;
         $display("[TB] FAIL clr_vs_frame got %b/%0d/%b exp 0/%0d/0", keepErr, frameCnt, underflow, expF);
      end
      sIf.tkeep = 32'h0F0F_0F0F;
      sIf.tlast = 1'b0;
      tick();
      checks++;
      if ({keepErr, frameCnt} !== {1'b1, 16'd0}) begin
         errors++;
         $display("[TB] FAIL clr_vs_keep got %b/%0d exp 1/0", keepErr, frameCnt);
      end
      sIf.tvalid = 1'b0;
      sIf.tkeep  = 32'hFFFF_FFFF;
      tick();
      statusClr = 1'b0;
      checks++;
      if ({underflow, keepErr, underflowCnt, frameCnt} !== 34'd0) begin
         errors++;
         $display("[TB] FAIL clr_all got %h exp 0", {underflow, keepErr, underflowCnt, frameCnt});
      end
   endtask

   task automatic test_flush_stop();
      quiesce();
      playEn     = 1'b1;
      mIf.tready = 1'b0;
      sIf.tvalid = 1'b1;
      for (int i = 0; i < 11; i++) begin
         sIf.tdata = randWord();
         tick();
      end
      sIf.tvalid = 1'b0;
      checks++;
      if ({state, fifoLevel, mIf.tvalid} !== {2'd2, 5'd10, 1'b1}) begin
         errors++;
         $display("[TB] FAIL flush_pre got %0d/%0d/%b exp 2/10/1", state, fifoLevel, mIf.tvalid);
      end
      fifoFlush = 1'b1;
      tick();
      fifoFlush = 1'b0;
      checks++;
      if ({state, fifoLevel, sIf.tready} !== {2'd2, 5'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL flush_level got %0d/%0d/%b exp 2/0/1", state, fifoLevel, sIf.tready);
      end
      mIf.tready = 1'b1;
      tick();
      checks++;
      if ({underflow, mIf.tvalid, mIf.tdata} !== {1'b1, 1'b1, 256'd0}) begin
         errors++;
         $display("[TB] FAIL flush_underflow got %b/%b/%h exp 1/1/0", underflow, mIf.tvalid, mIf.tdata);
      end
      playEn = 1'b0;
      tick();
      checks++;
      if ({mIf.tvalid, state, mIf.tdata} !== {1'b0, 2'd0, 256'd0}) begin
         errors++;
         $display("[TB] FAIL stop got %b/%0d/%h exp 0/0/0", mIf.tvalid, state, mIf.tdata);
      end
   endtask

   task automatic test_random();
      logic [15:0] expU, expF;
      quiesce();
      playEn = 1'b1;
      for (int c = 0; c < 600; c++) begin
         sIf.tvalid = ($urandom_range(0, 3) != 0);
         sIf.tdata  = randWord();
         sIf.tkeep  = ($urandom_range(0, 7) == 0) ? 32'($urandom()) : 32'hFFFF_FFFF;
         sIf.tlast  = ($urandom_range(0, 7) == 0);
         mIf.tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 39) == 0) playEn = ~playEn;
         fifoFlush  = ($urandom_range(0, 59) == 0);
         statusClr  = ($urandom_range(0, 49) == 0);
         tick();
         expU = STATS ? 16'(mUcnt) : 16'd0;
         expF = STATS ? 16'(mFcnt) : 16'd0;
         checks++;
         if ({mIf.tvalid, sIf.tready, fifoLevel, state} !== {mState == 2, mq.size() != DEPTH, 5'(mq.size()), 2'(mState)}) begin
            errors++;
            $display("[TB] FAIL rand_ctrl cyc %0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", c, mIf.tvalid, sIf.tready, fifoLevel, state, mState == 2, mq.size() != DEPTH, mq.size(), mState);
         end
         checks++;
         if (mIf.tdata !== mOut) begin
            errors++;
            $display("[TB] FAIL rand_tdata cyc %0d got %h exp %h", c, mIf.tdata, mOut);
         end
         checks++;
         if ({underflow, keepErr, underflowCnt, frameCnt} !== {mUf, mKe, expU, expF}) begin
            errors++;
            $display("[TB] FAIL rand_status cyc %0d got %b/%b/%0d/%0d exp %b/%b/%0d/%0d", c, underflow, keepErr, underflowCnt, frameCnt, mUf, mKe, expU, expF);
         end
      end
      fifoFlush = 1'b0;
      statusClr = 1'b0;
   endtask

   task automatic test_async_reset();
      quiesce();
      playEn     = 1'b1;
      mIf.tready = 1'b1;
      sIf.tvalid = 1'b1;
      sIf.tkeep  = 32'h00FF_FFFF;
      sIf.tlast  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         sIf.tdata = randWord();
         tick();
      end
      checks++;
      if ({state, mIf.tvalid} !== {2'd2, 1'b1}) begin
         errors++;
         $display("[TB] FAIL arst_pre got %0d/%b exp 2/1", state, mIf.tvalid);
      end
      #2;
      rstb = 1'b0;
      #1;
      checks++;
      if ({sIf.tready, mIf.tvalid, fifoLevel, state, mIf.tdata} !== {1'b1, 1'b0, 5'd0, 2'd0, 256'd0}) begin
         errors++;
         $display("[TB] FAIL arst_outputs got %b/%b/%0d/%0d/%h exp 1/0/0/0/0", sIf.tready, mIf.tvalid, fifoLevel, state, mIf.tdata);
      end
      checks++;
      if ({underflow, keepErr, underflowCnt, frameCnt} !== 34'd0) begin
         errors++;
         $display("[TB] FAIL arst_status got %h exp 0", {underflow, keepErr, underflowCnt, frameCnt});
      end
      sIf.tvalid = 1'b0;
      playEn     = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      tick();
   endtask

   initial begin
      sIf.tvalid = 1'b0;
      sIf.tdata  = '0;
      sIf.tkeep  = 32'hFFFF_FFFF;
      sIf.tlast  = 1'b0;
      mIf.tready = 1'b0;
      test_reset();
      test_prime_play();
      test_underflow();
      test_backpressure();
      test_keep_last();
      test_flush_stop();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
